fetch_stage_if_id: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 16-bit 5-stage pipelined CPU.
- Holds the PC and drives the instruction-memory address.
- Computes PC+2 and selects between sequential and branch/jump redirect.
- Registers the fetched instruction and its next-PC into the ID stage, honouring hazard-unit stall/hold, control-unit flush and halt.

---
 rtl/fetch_stage_if_id_if.sv | 33 +++
 rtl/fetch_stage_if_id.sv | 101 ++++++++++
 tb/tb_fetch_stage_if_id.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if_id_if.sv
// rtl/fetch_stage_if_id_if.sv - fetch stage / IF-ID bundle between hazard, control, imem and the fetch block
interface fetch_stage_if_id_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 16
);
  logic                   pc_stop;
  logic                   if_id_buffer_hold;
  logic                   if_id_buffer_flush;
  logic                   if_pc_mux;
  logic [ADDR_WIDTH-1:0]  ex_if_branch_location_result;
  logic                   ctrl_halt;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic [ADDR_WIDTH-1:0]  if_address_from_pc;
  logic [ADDR_WIDTH-1:0]  if_adder_result_address;
  logic [INSTR_WIDTH-1:0] id_instruction;
  logic [ADDR_WIDTH-1:0]  id_pc_next_address;
  logic                   id_valid;
  logic                   halted;

  modport master (
    output pc_stop, if_id_buffer_hold, if_id_buffer_flush, if_pc_mux,
           ex_if_branch_location_result, ctrl_halt, imem_data,
    input  if_address_from_pc, if_adder_result_address, id_instruction,
           id_pc_next_address, id_valid, halted
  );

  modport slave (
    input  pc_stop, if_id_buffer_hold, if_id_buffer_flush, if_pc_mux,
           ex_if_branch_location_result, ctrl_halt, imem_data,
    output if_address_from_pc, if_adder_result_address, id_instruction,
           id_pc_next_address, id_valid, halted
  );
endinterface

// File: rtl/fetch_stage_if_id.sv
// rtl/fetch_stage_if_id.sv - PC register, PC+2 adder, redirect mux and IF/ID pipeline register
module fetch_stage_if_id #(
  parameter int                    ADDR_WIDTH      = 16,
  parameter int                    INSTR_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = 16'h0000,
  parameter int                    PC_INCREMENT    = 2,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTRUCTION = 16'h0000
) (
  input  logic                clock,
  input  logic                reset,
  fetch_stage_if_id_if.slave  bus
);
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [ADDR_WIDTH-1:0]  w_pc_next;
  logic [ADDR_WIDTH-1:0]  w_pc_plus;
  logic [ADDR_WIDTH-1:0]  w_target;
  logic [INSTR_WIDTH-1:0] r_id_instr;
  logic [INSTR_WIDTH-1:0] w_id_instr_next;
  logic [ADDR_WIDTH-1:0]  r_id_next_pc;
  logic [ADDR_WIDTH-1:0]  w_id_next_pc_next;
  logic                   r_id_valid;
  logic                   w_id_valid_next;
  logic                   w_bubble;

  // Modulo-2^ADDR_WIDTH add; wrap from the top of memory is silent.
  assign w_pc_plus = r_pc + ADDR_WIDTH'(PC_INCREMENT);
  assign w_target  = {bus.ex_if_branch_location_result[ADDR_WIDTH-1:1], 1'b0};
  assign w_bubble  = bus.if_id_buffer_flush | bus.if_pc_mux | bus.ctrl_halt;

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_id_instr_next   = r_id_instr;
    w_id_next_pc_next = r_id_next_pc;
    w_id_valid_next   = r_id_valid;
    case (r_state)
      ST_RUN: begin
        if (bus.ctrl_halt) begin
          w_state_next = ST_HALTED;
        end
        if (bus.ctrl_halt) begin
          w_pc_next = r_pc;
        end else if (bus.if_pc_mux) begin
          w_pc_next = w_target;
        end else if (bus.pc_stop) begin
          w_pc_next = r_pc;
        end else begin
          w_pc_next = w_pc_plus;
        end
        // The word fetched during a redirect is on the wrong path, so it becomes a bubble.
        if (w_bubble) begin
          w_id_instr_next   = NOP_INSTRUCTION;
          w_id_next_pc_next = '0;
          w_id_valid_next   = 1'b0;
        end else if (!bus.if_id_buffer_hold) begin
          w_id_instr_next   = bus.imem_data;
          w_id_next_pc_next = w_pc_plus;
          w_id_valid_next   = 1'b1;
        end
      end
      ST_HALTED: begin
        w_id_instr_next   = NOP_INSTRUCTION;
        w_id_next_pc_next = '0;
        w_id_valid_next   = 1'b0;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_id_instr   <= NOP_INSTRUCTION;
      r_id_next_pc <= '0;
      r_id_valid   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_id_instr   <= w_id_instr_next;
      r_id_next_pc <= w_id_next_pc_next;
      r_id_valid   <= w_id_valid_next;
    end
  end

  assign bus.if_address_from_pc      = r_pc;
  assign bus.if_adder_result_address = w_pc_plus;
  assign bus.id_instruction          = r_id_instr;
  assign bus.id_pc_next_address      = r_id_next_pc;
  assign bus.id_valid                = r_id_valid;
  assign bus.halted                  = (r_state == ST_HALTED);
endmodule

// File: tb/tb_fetch_stage_if_id.sv
// tb/tb_fetch_stage_if_id.sv - directed bench for fetch_stage_if_id; imem returns 16'h1000 + address
module tb_fetch_stage_if_id;
  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  fetch_stage_if_id_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(16)) bus ();

  fetch_stage_if_id dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  assign bus.imem_data = 16'h1000 + bus.if_address_from_pc;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_id(input string tag, input logic [15:0] instr, input logic [15:0] npc,
                          input logic valid);
    check({tag, ".instr"}, 32'(bus.id_instruction), 32'(instr));
    check({tag, ".npc"}, 32'(bus.id_pc_next_address), 32'(npc));
    check({tag, ".valid"}, 32'(bus.id_valid), 32'(valid));
  endtask

  task automatic clear_ctrl();
    bus.pc_stop                      = 1'b0;
    bus.if_id_buffer_hold            = 1'b0;
    bus.if_id_buffer_flush           = 1'b0;
    bus.if_pc_mux                    = 1'b0;
    bus.ex_if_branch_location_result = 16'h0000;
    bus.ctrl_halt                    = 1'b0;
  endtask

  initial begin
    clear_ctrl();
    reset = 1'b1;
    tick();
    check("rst.pc", 32'(bus.if_address_from_pc), 32'h0000);
    check("rst.adder", 32'(bus.if_adder_result_address), 32'h0002);
    check_id("rst", 16'h0000, 16'h0000, 1'b0);
    check("rst.halted", 32'(bus.halted), 32'h0);
    reset = 1'b0;

    tick();
    tick();
    tick();
    check("run.pc", 32'(bus.if_address_from_pc), 32'h0006);
    check_id("run", 16'h1004, 16'h0006, 1'b1);
    tick();
    check("run.pc8", 32'(bus.if_address_from_pc), 32'h0008);

    bus.pc_stop = 1'b1;
    bus.if_id_buffer_hold = 1'b1;
    tick();
    check("stall1.pc", 32'(bus.if_address_from_pc), 32'h0008);
    check("stall1.adder", 32'(bus.if_adder_result_address), 32'h000A);
    check_id("stall1", 16'h1006, 16'h0008, 1'b1);
    tick();
    check("stall2.pc", 32'(bus.if_address_from_pc), 32'h0008);
    check_id("stall2", 16'h1006, 16'h0008, 1'b1);
    clear_ctrl();
    tick();
    check("resume.pc", 32'(bus.if_address_from_pc), 32'h000A);
    check_id("resume", 16'h1008, 16'h000A, 1'b1);

    bus.if_pc_mux = 1'b1;
    bus.pc_stop = 1'b1;
    bus.ex_if_branch_location_result = 16'h0041;
    tick();
    check("br.pc", 32'(bus.if_address_from_pc), 32'h0040);
    check_id("br", 16'h0000, 16'h0000, 1'b0);
    clear_ctrl();
    tick();
    check("br2.pc", 32'(bus.if_address_from_pc), 32'h0042);
    check_id("br2", 16'h1040, 16'h0042, 1'b1);

    bus.if_pc_mux = 1'b1;
    bus.ex_if_branch_location_result = 16'h0010;
    tick();
    check("to10.pc", 32'(bus.if_address_from_pc), 32'h0010);
    clear_ctrl();
    bus.if_id_buffer_flush = 1'b1;
    bus.if_id_buffer_hold = 1'b1;
    tick();
    check("flush.pc", 32'(bus.if_address_from_pc), 32'h0012);
    check_id("flush", 16'h0000, 16'h0000, 1'b0);
    clear_ctrl();
    tick();
    check_id("post_flush", 16'h1012, 16'h0014, 1'b1);
    bus.if_id_buffer_hold = 1'b1;
    tick();
    check("hold.pc", 32'(bus.if_address_from_pc), 32'h0016);
    check_id("hold", 16'h1012, 16'h0014, 1'b1);
    clear_ctrl();

    bus.if_pc_mux = 1'b1;
    bus.ex_if_branch_location_result = 16'hFFFE;
    tick();
    check("wrap.pc", 32'(bus.if_address_from_pc), 32'hFFFE);
    check("wrap.adder", 32'(bus.if_adder_result_address), 32'h0000);
    clear_ctrl();
    tick();
    check("wrap2.pc", 32'(bus.if_address_from_pc), 32'h0000);
    check_id("wrap2", 16'h0FFE, 16'h0000, 1'b1);

    bus.if_pc_mux = 1'b1;
    bus.ex_if_branch_location_result = 16'h0020;
    tick();
    clear_ctrl();
    check("to20.pc", 32'(bus.if_address_from_pc), 32'h0020);
    bus.ctrl_halt = 1'b1;
    tick();
    check("halt.pc", 32'(bus.if_address_from_pc), 32'h0020);
    check("halt.halted", 32'(bus.halted), 32'h1);
    check_id("halt", 16'h0000, 16'h0000, 1'b0);
    clear_ctrl();
    for (int i = 0; i < 10; i++) begin
      bus.pc_stop = 1'($urandom_range(0, 1));
      bus.if_pc_mux = 1'($urandom_range(0, 1));
      bus.if_id_buffer_hold = 1'($urandom_range(0, 1));
      bus.ex_if_branch_location_result = 16'($urandom);
      tick();
      check("halted.pc", 32'(bus.if_address_from_pc), 32'h0020);
      check("halted.flag", 32'(bus.halted), 32'h1);
      check("halted.valid", 32'(bus.id_valid), 32'h0);
    end

    reset = 1'b1;
    bus.if_pc_mux = 1'b1;
    bus.ex_if_branch_location_result = 16'h0080;
    tick();
    check("rst2.pc", 32'(bus.if_address_from_pc), 32'h0000);
    check("rst2.halted", 32'(bus.halted), 32'h0);
    check_id("rst2", 16'h0000, 16'h0000, 1'b0);
    reset = 1'b0;
    clear_ctrl();
    tick();
    check("rerun.pc", 32'(bus.if_address_from_pc), 32'h0002);
    check_id("rerun", 16'h1000, 16'h0002, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
